// File: rtl/rv32_types.sv
// Shared fetch-stage types: machine word, fetch->decode buffer and fetch FSM states.
package rv32_types;

  typedef logic [31:0] rv32_word;

  typedef struct packed {
    rv32_word pc;
    logic     generate_nop;
  } fetch_decode_buffer_t;

  typedef enum logic [1:0] {
    S_START,
    S_REQ,
    S_WAIT,
    S_FLUSH
  } fetch_state_e;

  localparam rv32_word PC_STEP = 32'd4;

  function automatic rv32_word align_word(input rv32_word addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/rv32_pc_gen.sv
// Fetch PC register: holds by default, steps by one instruction or loads a redirect target.
module rv32_pc_gen
  import rv32_types::*;
#(
  parameter rv32_word RESET_PC = 32'h0000_0000
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     pc_inc,
  input  logic     pc_load,
  input  rv32_word load_pc,
  output rv32_word pc
);

  rv32_word pc_q;
  rv32_word pc_d;

  // load outranks increment so a redirect always lands on its target
  always_comb begin
    pc_d = pc_q;
    if (pc_load) begin
      pc_d = load_pc;
    end else if (pc_inc) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/rv32_fetch_stage.sv
// RV32 fetch stage: single-outstanding imem request FSM and the fetch->decode buffer.
// Optional misaligned-redirect trap enabled by RV32_FETCH_ALIGN_CHECK_EN.
//
//   state   | meaning
//   S_START | first cycle after reset, no request
//   S_REQ   | request for pc driven this cycle
//   S_WAIT  | request outstanding, response goes to decode
//   S_FLUSH | request outstanding after a redirect, response dropped
module rv32_fetch_stage
  import rv32_types::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 stall,
  input  logic                 stop,
  input  logic                 redirect,
  input  rv32_word             redirect_pc,
  output logic                 imem_req,
  output rv32_word             imem_addr,
  input  logic                 imem_ready,
  output fetch_decode_buffer_t fetch_decode_buff,
  output logic                 fetch_misaligned
);

  fetch_state_e         state_q, state_d;
  fetch_decode_buffer_t buff_q, buff_d;
  rv32_word             addr_q, addr_d;
  logic                 pending_q, pending_d;
  logic                 misaligned_q, misaligned_d;

  rv32_word pc;
  logic     pc_inc;
  logic     pc_load;
  rv32_word redirect_tgt;
  logic     redirect_bad;
  logic     resp_seen;

`ifdef RV32_FETCH_ALIGN_CHECK_EN
  assign redirect_tgt = redirect_pc;
  assign redirect_bad = |redirect_pc[1:0];
`else
  logic unused_redirect_lsbs;
  assign redirect_tgt         = align_word(redirect_pc);
  assign redirect_bad         = 1'b0;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
`endif

  rv32_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk     (clk),
    .resetn  (resetn),
    .pc_inc  (pc_inc),
    .pc_load (pc_load),
    .load_pc (redirect_tgt),
    .pc      (pc)
  );

  // a redirect suppresses the request so a wrong-path fetch never goes out
  assign imem_req = resetn && (state_q == S_REQ) && !stop && !stall
                    && !redirect && !misaligned_q;
  assign imem_addr = (state_q == S_REQ) ? pc : addr_q;
  assign resp_seen = imem_ready || pending_q;

  always_comb begin
    state_d      = state_q;
    buff_d       = buff_q;
    addr_d       = addr_q;
    pending_d    = pending_q;
    misaligned_d = misaligned_q;
    pc_inc       = 1'b0;
    pc_load      = 1'b0;

    if (stop) begin
      state_d = state_q;
    end else if (redirect) begin
      pc_load      = 1'b1;
      buff_d       = '{pc: redirect_tgt, generate_nop: 1'b1};
      pending_d    = 1'b0;
      misaligned_d = misaligned_q | redirect_bad;
      unique case (state_q)
        S_WAIT, S_FLUSH: state_d = resp_seen ? S_REQ : S_FLUSH;
        default:         state_d = S_REQ;
      endcase
    end else if (stall) begin
      // a response landing during a stall is parked until decode can take it
      if ((state_q == S_WAIT || state_q == S_FLUSH) && imem_ready) begin
        pending_d = 1'b1;
      end
    end else begin
      pending_d = 1'b0;
      buff_d    = '{pc: pc, generate_nop: 1'b1};
      unique case (state_q)
        S_START: state_d = S_REQ;
        S_REQ: begin
          if (imem_req) begin
            addr_d = pc;
            if (imem_ready) begin
              buff_d = '{pc: pc, generate_nop: 1'b0};
              pc_inc = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (resp_seen) begin
            buff_d  = '{pc: pc, generate_nop: 1'b0};
            pc_inc  = 1'b1;
            state_d = S_REQ;
          end
        end
        S_FLUSH: begin
          if (resp_seen) begin
            state_d = S_REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_START;
      buff_q       <= '{pc: RESET_PC, generate_nop: 1'b1};
      addr_q       <= RESET_PC;
      pending_q    <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      buff_q       <= buff_d;
      addr_q       <= addr_d;
      pending_q    <= pending_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign fetch_decode_buff = buff_q;
  assign fetch_misaligned  = misaligned_q;

endmodule

// File: tb/tb_rv32_fetch_stage.sv
// Self-checking bench for rv32_fetch_stage: directed vector table, randomized run
// against a flag-based reference model, and a misaligned-redirect sequence.
module tb_rv32_fetch_stage;
  import rv32_types::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 stall = 1'b0;
  logic                 stop = 1'b0;
  logic                 redirect = 1'b0;
  logic [31:0]          redirect_pc = '0;
  logic                 imem_req;
  logic [31:0]          imem_addr;
  logic                 imem_ready = 1'b0;
  fetch_decode_buffer_t fetch_decode_buff;
  logic                 fetch_misaligned;

  int n_tests = 0;
  int n_fail  = 0;

  rv32_fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .stall             (stall),
    .stop              (stop),
    .redirect          (redirect),
    .redirect_pc       (redirect_pc),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .imem_ready        (imem_ready),
    .fetch_decode_buff (fetch_decode_buff),
    .fetch_misaligned  (fetch_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rn, st, sp, rd;
    logic [31:0] rp;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    bit          e_nop;
  } vec_t;

  vec_t vec[$];

  function automatic vec_t mk(bit rn, bit st, bit sp, bit rd, logic [31:0] rp, bit rdy,
                              bit e_req, logic [31:0] e_addr, logic [31:0] e_pc, bit e_nop);
    vec_t v;
    v.rn = rn; v.st = st; v.sp = sp; v.rd = rd; v.rp = rp; v.rdy = rdy;
    v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc; v.e_nop = e_nop;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inputs change on the falling edge; outputs are sampled 2 time units later
  task automatic drive(input bit rn, input bit st, input bit sp, input bit rd, input logic [31:0] rp);
    @(negedge clk);
    resetn = rn; stall = st; stop = sp; redirect = rd; redirect_pc = rp; imem_ready = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, '0);
    drive(0, 0, 0, 0, '0);
  endtask

  // reference model state
  logic [31:0] m_pc, m_out, m_bpc;
  bit          m_bnop, m_started, m_busy, m_drop, m_held;
  bit          mem_busy;
  int          mem_cnt;

  initial begin
    // rn st sp rd rp          rdy | req addr          buf.pc        nop
    vec.push_back(mk(1,0,0,0,32'h0,       0, 0,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 0,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h104,      32'h100,      0));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 0,32'h104,      32'h104,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h108,      32'h104,      0));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 0,32'h108,      32'h108,      1));
    vec.push_back(mk(0,0,0,0,32'h0,       0, 0,32'h10C,      32'h108,      0));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 0,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 0,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 0,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 0,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h104,      32'h100,      0));
    vec.push_back(mk(1,1,0,0,32'h0,       1, 0,32'h104,      32'h104,      1));
    vec.push_back(mk(1,1,0,0,32'h0,       0, 0,32'h104,      32'h104,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 0,32'h104,      32'h104,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h108,      32'h104,      0));
    vec.push_back(mk(1,0,0,1,32'h200,     0, 0,32'h108,      32'h108,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 0,32'h108,      32'h200,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h200,      32'h200,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 0,32'h200,      32'h200,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h204,      32'h200,      0));
    vec.push_back(mk(1,1,0,1,32'h200,     0, 0,32'h204,      32'h204,      1));
    vec.push_back(mk(1,0,1,1,32'h300,     0, 0,32'h204,      32'h200,      1));
    vec.push_back(mk(1,0,1,0,32'h0,       0, 0,32'h204,      32'h200,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 0,32'h204,      32'h200,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h200,      32'h200,      1));
    vec.push_back(mk(1,0,0,1,32'h404,     1, 0,32'h200,      32'h200,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 1,32'h404,      32'h404,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 1,32'h408,      32'h404,      0));
    vec.push_back(mk(1,1,0,0,32'h0,       0, 0,32'h40C,      32'h408,      0));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h40C,      32'h408,      0));
    vec.push_back(mk(0,0,0,0,32'h0,       0, 0,32'h40C,      32'h40C,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 0,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 0,32'h100,      32'h100,      1));
    vec.push_back(mk(1,0,0,1,32'hFFFFFFFC,0, 0,32'h104,      32'h100,      0));
    vec.push_back(mk(1,0,0,0,32'h0,       1, 1,32'hFFFFFFFC, 32'hFFFFFFFC, 1));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 1,32'h0,        32'hFFFFFFFC, 0));
    vec.push_back(mk(1,0,0,0,32'h0,       0, 0,32'h0,        32'h0,        1));

    // directed table
    do_reset();
    foreach (vec[i]) begin
      drive(vec[i].rn, vec[i].st, vec[i].sp, vec[i].rd, vec[i].rp);
      imem_ready = vec[i].rdy;
      #1;
      chk($sformatf("row%0d req", i),  {31'b0, imem_req},                   {31'b0, vec[i].e_req});
      chk($sformatf("row%0d addr", i), imem_addr,                           vec[i].e_addr);
      chk($sformatf("row%0d bpc", i),  fetch_decode_buff.pc,                vec[i].e_pc);
      chk($sformatf("row%0d nop", i),  {31'b0, fetch_decode_buff.generate_nop}, {31'b0, vec[i].e_nop});
      chk($sformatf("row%0d mis", i),  {31'b0, fetch_misaligned},           32'h0);
    end

    // randomized run against the reference model
    do_reset();
    m_pc = RST_PC; m_out = RST_PC; m_bpc = RST_PC; m_bnop = 1'b1;
    m_started = 1'b0; m_busy = 1'b0; m_drop = 1'b0; m_held = 1'b0;
    mem_busy = 1'b0; mem_cnt = 0;
    for (int c = 0; c < 1500; c++) begin
      bit st, sp, rd, rdy, exp_req;
      logic [31:0] rp, exp_addr;
      int lat;
      st = ($urandom_range(0, 99) < 20);
      sp = ($urandom_range(0, 99) < 8);
      rd = ($urandom_range(0, 99) < 7);
      rp = $urandom() & 32'hFFFF_FFFC;
      drive(1, st, sp, rd, rp);
      rdy = 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          if (!sp) begin
            rdy = 1'b1;
            mem_busy = 1'b0;
          end
        end else begin
          mem_cnt--;
        end
      end else if (imem_req) begin
        lat = $urandom_range(0, 3);
        if (lat == 0) rdy = 1'b1;
        else begin
          mem_busy = 1'b1;
          mem_cnt = lat - 1;
        end
      end
      imem_ready = rdy;
      #1;
      exp_req  = m_started && !m_busy && !st && !sp && !rd;
      exp_addr = m_busy ? m_out : m_pc;
      chk($sformatf("rnd%0d req", c),  {31'b0, imem_req},  {31'b0, exp_req});
      chk($sformatf("rnd%0d addr", c), imem_addr,          exp_addr);
      chk($sformatf("rnd%0d bpc", c),  fetch_decode_buff.pc, m_bpc);
      chk($sformatf("rnd%0d nop", c),  {31'b0, fetch_decode_buff.generate_nop}, {31'b0, m_bnop});
      chk($sformatf("rnd%0d mis", c),  {31'b0, fetch_misaligned}, 32'h0);
      if (!sp) begin
        if (rd) begin
          m_pc = rp; m_bpc = rp; m_bnop = 1'b1;
          if (m_busy && !(rdy || m_held)) m_drop = 1'b1;
          else begin
            m_busy = 1'b0;
            m_drop = 1'b0;
          end
          m_held = 1'b0;
          m_started = 1'b1;
        end else if (st) begin
          if (m_busy && rdy) m_held = 1'b1;
        end else begin
          m_bpc = m_pc; m_bnop = 1'b1;
          if (!m_started) m_started = 1'b1;
          else if (!m_busy) begin
            m_out = m_pc;
            if (rdy) begin
              m_bnop = 1'b0;
              m_pc = m_pc + 32'd4;
            end else m_busy = 1'b1;
          end else if (rdy || m_held) begin
            if (!m_drop) begin
              m_bnop = 1'b0;
              m_pc = m_pc + 32'd4;
            end
            m_busy = 1'b0;
            m_drop = 1'b0;
          end
          m_held = 1'b0;
        end
      end
    end

    // redirect with nonzero low address bits
    do_reset();
    drive(1, 0, 0, 0, '0);
    #1;
    drive(1, 0, 0, 1, 32'h202);
    #1;
    chk("mis redirect req", {31'b0, imem_req}, 32'h0);
`ifdef RV32_FETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, '0);
      #1;
      chk($sformatf("mis hold%0d req", k), {31'b0, imem_req}, 32'h0);
      chk($sformatf("mis hold%0d flag", k), {31'b0, fetch_misaligned}, 32'h1);
    end
    do_reset();
    drive(1, 0, 0, 0, '0);
    #1;
    chk("mis after reset flag", {31'b0, fetch_misaligned}, 32'h0);
    drive(1, 0, 0, 0, '0);
    #1;
    chk("mis after reset req", {31'b0, imem_req}, 32'h1);
`else
    drive(1, 0, 0, 0, '0);
    #1;
    chk("lsb req",  {31'b0, imem_req}, 32'h1);
    chk("lsb addr", imem_addr, 32'h200);
    chk("lsb bpc",  fetch_decode_buff.pc, 32'h200);
    chk("lsb flag", {31'b0, fetch_misaligned}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_fetch_stage.md
RV32_FETCH_STAGE -- requirements
Module: rv32_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  in  1  clock; all state on rising edge.
REQ-003 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port stall  in  1  decode hazard stall; hold buffer and PC.
REQ-005 SHALL have port stop  in  1  global pipeline freeze; hold all state.
REQ-006 SHALL have port redirect  in  1  taken branch/jump/trap; replace PC.
REQ-007 SHALL have port redirect_pc  in  32  redirect target (rv32_word).
REQ-008 SHALL have port imem_req  out  1  instruction memory request, one-cycle pulse per fetch.
REQ-009 SHALL have port imem_addr  out  32  fetch address, valid while imem_req=1 and held until response.
REQ-010 SHALL have port imem_ready  in  1  response valid; instruction data presented directly to decode.
REQ-011 SHALL have port fetch_decode_buff  out  fetch_decode_buffer_t  {pc, generate_nop} to decode.
REQ-012 SHALL have port fetch_misaligned  out  1  sticky misaligned-redirect flag.

Function
REQ-013 SHALL implement FSM states S_START, S_REQ, S_WAIT, S_FLUSH.
REQ-014 S_START: no request; next cycle -> S_REQ.
REQ-015 S_REQ: imem_req=1, imem_addr=pc; -> S_WAIT unless imem_ready same cycle, then remain in S_REQ with pc+4.
REQ-016 S_WAIT: imem_req=0, imem_addr held; on imem_ready -> S_REQ.
REQ-017 On imem_ready (not stall/stop/redirect): buffer <= {pc of that request, generate_nop=0}; pc <= pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-018 Any cycle without accepted response: buffer <= {pc, generate_nop=1} (bubble).
REQ-019 stall=1: buffer, pc, FSM held; imem_req=0; imem_addr held; a response arriving during stall SHALL be latched as pending and delivered on the first non-stall cycle.
REQ-020 stop=1: every register held, imem_req=0; stop has priority over stall.
REQ-021 redirect=1 (not stop): pc <= redirect_pc, buffer <= {redirect_pc, generate_nop=1}, pending cleared; priority over stall.
REQ-022 Redirect with request outstanding (S_WAIT without imem_ready): -> S_FLUSH; the next imem_ready SHALL be discarded (bubble), then -> S_REQ.
REQ-023 Redirect in S_REQ or S_WAIT with simultaneous imem_ready: response discarded, -> S_REQ.
REQ-024 Redirect in S_FLUSH: new target replaces pc, remain in S_FLUSH.
REQ-025 At most one request SHALL be outstanding.

Reset
REQ-026 On resetn=0: pc=RESET_PC, FSM=S_START, buffer={RESET_PC, generate_nop=1}, imem_req=0, imem_addr=RESET_PC, pending=0, fetch_misaligned=0.
REQ-027 Reset SHALL abandon any outstanding request; a late imem_ready in S_START SHALL be ignored.

Configuration
REQ-028 Macro RV32_FETCH_ALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]!=0 SHALL set fetch_misaligned (cleared only by reset) and SHALL not issue requests until reset.
REQ-029 Macro undefined: fetch_misaligned tied 0; redirect_pc[1:0] ignored (forced to 0).

Structure
REQ-030 fetch_decode_buffer_t, rv32_word and fetch FSM state enum SHALL live in rv32_types.
REQ-031 A sub-module rv32_pc_gen (pc register, +4 increment, redirect mux) SHALL be used; FSM and buffer remain in the top.

Verification
REQ-032 Reset, RESET_PC=0x100, imem_ready one cycle after each req -> imem_addr 0x100,0x104,0x108; buffer pc follows with generate_nop=0 on response cycles.
REQ-033 imem_ready delayed 3 cycles -> 3 bubbles (generate_nop=1), then pc=0x100 delivered once.
REQ-034 stall for 2 cycles with response arriving during stall -> buffer unchanged, no imem_req; pending 0x104 delivered on first non-stall cycle.
REQ-035 redirect to 0x200 while request for 0x108 outstanding -> stale response discarded, next imem_addr=0x200, first valid buffer pc=0x200.
REQ-036 redirect and stall same cycle -> redirect wins, buffer={0x200, generate_nop=1}; stop same cycle -> nothing changes.
REQ-037 With RV32_FETCH_ALIGN_CHECK_EN, redirect to 0x202 -> fetch_misaligned=1, imem_req stays 0 until resetn=0.
